mm_result_drain: RTL and testbench

- Downstream stage of the NxN sum-stationary systolic multiplier.
- Waits for the array's result-valid, snapshots all N*N accumulators into a local buffer, and pulses the array's synchronous clear so the next product can start computing immediately.
- Streams the buffered result out one row (N elements) per beat on a valid/ready interface.
- Backpressure on the output holds the array: a new snapshot is taken only after the previous one is fully drained.

---
 rtl/mm_result_drain.sv | 161 ++++++++++++++++
 tb/tb_mm_result_drain.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mm_result_drain.sv
// mm_result_drain
//   Drains the NxN sum-stationary systolic multiplier. When the array raises
//   its result-valid, all N*N accumulators are snapshotted into a local
//   buffer and the array is cleared with a one-cycle pulse so it can start on
//   the next product. The buffered result is then streamed out one row per
//   beat on a valid/ready interface. A new snapshot is only taken once the
//   previous one has been fully drained, so output backpressure holds the
//   array.
//
// Ports
//   clk_i          clock, all state on the rising edge
//   reset_ni       asynchronous active-low reset
//   array_valid_i  array result valid (held until cleared)
//   array_c_i      N*N accumulators, element k = row k/N, column k%N
//   array_clear_o  one-cycle clear pulse to the array's synchronous reset
//   out_valid_o    row beat valid
//   out_ready_i    downstream accepts the beat
//   out_data_o     current row, element j = C[row][j]
//   out_row_o      index of the current row
//   out_last_o     high while the current row is N-1
//   busy_o         high whenever a result is being streamed
//   frame_count_o  number of fully drained results (wraps)
module mm_result_drain #(
    parameter int DATA_WIDTH      = 8,
    parameter int N               = 4,
    parameter int C_DATA_WIDTH    = (2 * DATA_WIDTH) + $clog2(N),
    parameter int FRAME_CNT_WIDTH = 16,
    localparam int ROW_W          = (N > 1) ? $clog2(N) : 1
) (
    input  logic                            clk_i,
    input  logic                            reset_ni,
    input  logic                            array_valid_i,
    input  logic [N*N*C_DATA_WIDTH-1:0]     array_c_i,
    output logic                            array_clear_o,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [N*C_DATA_WIDTH-1:0]       out_data_o,
    output logic [ROW_W-1:0]                out_row_o,
    output logic                            out_last_o,
    output logic                            busy_o,
    output logic [FRAME_CNT_WIDTH-1:0]      frame_count_o
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N - 1);

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    state_t                       state_q, state_d;
    logic [ROW_W-1:0]             row_q, row_d;
    logic                         clear_q, clear_d;
    logic                         valid_q, valid_d;
    logic                         last_q, last_d;
    logic                         busy_q, busy_d;
    logic [FRAME_CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                         capture;

    logic [C_DATA_WIDTH-1:0]      buf_q [N][N];

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        clear_d = 1'b0;
        valid_d = valid_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        capture = 1'b0;

        case (state_q)
            S_IDLE: begin
                // The clear pulse still in flight means the array's valid is
                // stale; waiting one cycle avoids re-capturing the same result.
                if (array_valid_i && !clear_q) begin
                    capture = 1'b1;
                    row_d   = '0;
                    state_d = S_STREAM;
                    clear_d = 1'b1;
                    valid_d = 1'b1;
                    last_d  = (LAST_ROW == '0);
                end
            end
            S_STREAM: begin
                if (out_ready_i) begin
                    if (row_q == LAST_ROW) begin
                        state_d = S_IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        cnt_d   = cnt_q + 1'b1;
                    end else begin
                        row_d  = row_q + 1'b1;
                        last_d = ((row_q + 1'b1) == LAST_ROW);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            clear_q <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            clear_q <= clear_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    // Result buffer: isolates the streamed data from the array, which is
    // free to start computing the next product once cleared.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int unsigned r = 0; r < N; r++) begin
                for (int unsigned c = 0; c < N; c++) begin
                    buf_q[r][c] <= '0;
                end
            end
        end else if (capture) begin
            for (int unsigned r = 0; r < N; r++) begin
                for (int unsigned c = 0; c < N; c++) begin
                    buf_q[r][c] <= array_c_i[(r*N + c)*C_DATA_WIDTH +: C_DATA_WIDTH];
                end
            end
        end
    end

    // Row select straight from registered buffer and row counter.
    always_comb begin
        out_data_o = '0;
        for (int unsigned j = 0; j < N; j++) begin
            out_data_o[j*C_DATA_WIDTH +: C_DATA_WIDTH] = buf_q[row_q][j];
        end
    end

    assign array_clear_o = clear_q;
    assign out_valid_o   = valid_q;
    assign out_row_o     = row_q;
    assign out_last_o    = last_q;
    assign busy_o        = busy_q;
    assign frame_count_o = cnt_q;

endmodule

// File: tb/tb_mm_result_drain.sv
// tb_mm_result_drain
//   Randomized bench for mm_result_drain. A queue of expected row beats is
//   filled on each capture and popped on each handshake; the array is modelled
//   as a valid flag that drops after each clear pulse. A second instance with
//   a 2-bit frame counter shares the stimulus to exercise counter wrap.
module tb_mm_result_drain;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int CW = 18;
    localparam int FW = 16;

    logic              clk_i = 1'b0;
    logic              reset_ni;
    logic              arr_valid;
    logic [N*N*CW-1:0] arr_c;
    logic              out_ready;

    logic              clear_a, valid_a, last_a, busy_a;
    logic [N*CW-1:0]   data_a;
    logic [1:0]        row_a;
    logic [FW-1:0]     cnt_a;

    logic              clear_b, valid_b, last_b, busy_b;
    logic [N*CW-1:0]   data_b;
    logic [1:0]        row_b;
    logic [1:0]        cnt_b;

    always #5 clk_i = ~clk_i;

    mm_result_drain #(
        .DATA_WIDTH(DW), .N(N), .C_DATA_WIDTH(CW), .FRAME_CNT_WIDTH(FW)
    ) dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .array_valid_i(arr_valid),
        .array_c_i(arr_c), .array_clear_o(clear_a), .out_valid_o(valid_a),
        .out_ready_i(out_ready), .out_data_o(data_a), .out_row_o(row_a),
        .out_last_o(last_a), .busy_o(busy_a), .frame_count_o(cnt_a)
    );

    mm_result_drain #(
        .DATA_WIDTH(DW), .N(N), .C_DATA_WIDTH(CW), .FRAME_CNT_WIDTH(2)
    ) dut_wrap (
        .clk_i(clk_i), .reset_ni(reset_ni), .array_valid_i(arr_valid),
        .array_c_i(arr_c), .array_clear_o(clear_b), .out_valid_o(valid_b),
        .out_ready_i(out_ready), .out_data_o(data_b), .out_row_o(row_b),
        .out_last_o(last_b), .busy_o(busy_b), .frame_count_o(cnt_b)
    );

    typedef struct {
        logic [N*CW-1:0] data;
        int unsigned     row;
    } beat_t;

    beat_t       exp_q[$];
    bit          m_clear;
    int unsigned m_frames;
    int unsigned n_vec;
    int unsigned n_err;
    int unsigned pidx;
    bit          ready_pat[7] = '{1, 0, 0, 1, 0, 1, 1};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        bit have = (exp_q.size() != 0);
        chk("valid", valid_a, have);
        chk("busy", busy_a, have);
        chk("clear", clear_a, m_clear);
        chk("frames", cnt_a, m_frames % 65536);
        chk("valid_w", valid_b, have);
        chk("busy_w", busy_b, have);
        chk("clear_w", clear_b, m_clear);
        chk("frames_w", cnt_b, m_frames % 4);
        if (have) begin
            chk("data", data_a, exp_q[0].data);
            chk("row", row_a, exp_q[0].row);
            chk("last", last_a, exp_q[0].row == N - 1);
            chk("data_w", data_b, exp_q[0].data);
            chk("last_w", last_b, exp_q[0].row == N - 1);
        end
    endtask

    // Set inputs for the next rising edge.
    //   rm: 0 = ready high, 1 = fixed pattern, 2 = random
    //   vp: percent chance per cycle the array presents a new result
    //   dm: 0 = k+1 pattern while idle / all ones otherwise, 1 = random
    task automatic drive(input int rm, input int vp, input int dm);
        case (rm)
            0:       out_ready = 1'b1;
            1: begin out_ready = ready_pat[pidx % 7]; pidx++; end
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        if (!arr_valid && $urandom_range(0, 99) < vp) arr_valid = 1'b1;
        for (int k = 0; k < N * N; k++) begin
            if (dm == 0)
                arr_c[k*CW +: CW] = (exp_q.size() == 0 && !m_clear) ? CW'(k + 1) : '1;
            else
                arr_c[k*CW +: CW] = CW'($urandom);
        end
    endtask

    // Advance one clock and apply the reference rules to the model.
    task automatic step();
        bit    pre_empty, hs, cap;
        beat_t b;
        @(posedge clk_i);
        #1;
        pre_empty = (exp_q.size() == 0);
        hs        = !pre_empty && out_ready;
        cap       = pre_empty && arr_valid && !m_clear;
        if (m_clear) arr_valid = 1'b0;
        if (hs) begin
            b = exp_q.pop_front();
            if (b.row == N - 1) m_frames++;
        end
        if (cap) begin
            for (int r = 0; r < N; r++) begin
                b.data = arr_c[r*N*CW +: N*CW];
                b.row  = r;
                exp_q.push_back(b);
            end
        end
        m_clear = cap;
        check_outputs();
    endtask

    task automatic run(input int n, input int rm, input int vp, input int dm);
        for (int i = 0; i < n; i++) begin
            drive(rm, vp, dm);
            step();
        end
    endtask

    task automatic check_reset_state();
        chk("rst_valid", valid_a, 1'b0);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_clear", clear_a, 1'b0);
        chk("rst_last", last_a, 1'b0);
        chk("rst_row", row_a, 0);
        chk("rst_data", data_a, 0);
        chk("rst_frames", cnt_a, 0);
        chk("rst_frames_w", cnt_b, 0);
    endtask

    initial begin
        bit found;
        n_vec     = 0;
        n_err     = 0;
        pidx      = 0;
        m_clear   = 1'b0;
        m_frames  = 0;
        reset_ni  = 1'b0;
        arr_valid = 1'b0;
        arr_c     = '0;
        out_ready = 1'b0;
        #12;
        check_reset_state();
        @(negedge clk_i);
        reset_ni = 1'b1;

        // Directed pattern, ready always high, array re-presents immediately.
        run(14, 0, 100, 0);
        // Stalling ready pattern.
        run(24, 1, 100, 0);

        // Async reset in the middle of the row-2 beat.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (exp_q.size() != 0 && exp_q[0].row == 2) found = 1'b1;
            else begin
                drive(0, 100, 1);
                step();
            end
        end
        chk("rst_wait", found, 1'b1);
        #2;
        reset_ni = 1'b0;
        #1;
        exp_q.delete();
        m_clear  = 1'b0;
        m_frames = 0;
        check_reset_state();
        @(negedge clk_i);
        reset_ni = 1'b1;

        // Randomized traffic.
        run(600, 2, 30, 1);
        run(150, 0, 100, 1);
        run(150, 2, 100, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
